// File: rtl/btn_led_ctrl.sv
// btn_led_ctrl: per-channel push-button synchroniser, debouncer and LED driver.
//
// Each channel synchronises one raw button through two flops, debounces it
// (the synchronised level must differ from the accepted level for DEB_CYCLES
// consecutive cycles), emits a one-cycle press pulse on each accepted press,
// and drives one LED in a run-time selectable mode.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset (clears every flop)
//   btn[N_CH]    raw asynchronous button levels, 1 = pressed
//   mode[2*N_CH] per-channel mode, bits [2i+1:2i]:
//                00 direct, 01 invert, 10 toggle, 11 blink
//   led[N_CH]    registered LED drive, 1 = on
//   press_pulse  registered one-cycle pulse per accepted press
//   press_count  (only with PRESS_COUNT_EN) 8-bit wrapping press counter per
//                channel, bits [8i+7:8i]
//
// Optional feature macro: PRESS_COUNT_EN (adds press_count and its counters).

module btn_led_ctrl #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned BLINK_HALF = 25000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     btn,
  input  logic [2*N_CH-1:0]   mode,
  output logic [N_CH-1:0]     led,
  output logic [N_CH-1:0]     press_pulse
`ifdef PRESS_COUNT_EN
  ,
  output logic [8*N_CH-1:0]   press_count
`endif
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES);
  localparam int unsigned BLK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    MODE_DIRECT = 2'b00,
    MODE_INVERT = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  // Synchroniser and debounce state
  logic [N_CH-1:0]  s1;
  logic [N_CH-1:0]  s2;
  logic [N_CH-1:0]  stable;
  logic [N_CH-1:0]  stable_nxt;
  logic [DEB_W-1:0] cnt     [N_CH];
  logic [DEB_W-1:0] cnt_nxt [N_CH];

  // Toggle state and LED next values
  logic [N_CH-1:0]  toggle;
  logic [N_CH-1:0]  toggle_nxt;
  logic [N_CH-1:0]  led_nxt;

  // Shared blink generator
  logic [BLK_W-1:0] blk_cnt;
  logic [BLK_W-1:0] blk_cnt_nxt;
  logic             wave;
  logic             wave_nxt;

  // Debounce: count consecutive cycles of disagreement, accept on the last one
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < N_CH; i++) begin
      cnt_nxt[i] = '0;
    end
    for (int i = 0; i < N_CH; i++) begin
      if (s2[i] != stable[i]) begin
        if (cnt[i] == DEB_LAST) begin
          stable_nxt[i] = s2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Blink counter: free-running, wave flips at each wrap
  always_comb begin
    blk_cnt_nxt = blk_cnt + BLK_W'(1);
    wave_nxt    = wave;
    if (blk_cnt == BLK_LAST) begin
      blk_cnt_nxt = '0;
      wave_nxt    = ~wave;
    end
  end

  // Toggle update and LED mode mux; toggle mode shows the post-update state
  always_comb begin
    toggle_nxt = toggle;
    led_nxt    = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (press_pulse[i] && (mode_e'(mode[2*i +: 2]) == MODE_TOGGLE)) begin
        toggle_nxt[i] = ~toggle[i];
      end
      case (mode_e'(mode[2*i +: 2]))
        MODE_DIRECT: led_nxt[i] = stable[i];
        MODE_INVERT: led_nxt[i] = ~stable[i];
        MODE_TOGGLE: led_nxt[i] = toggle_nxt[i];
        MODE_BLINK:  led_nxt[i] = stable[i] & wave;
      endcase
    end
  end

  // State registers; press_pulse is registered as (new stable & ~old stable)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      stable      <= '0;
      press_pulse <= '0;
      toggle      <= '0;
      led         <= '0;
      blk_cnt     <= '0;
      wave        <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
`ifdef PRESS_COUNT_EN
      press_count <= '0;
`endif
    end else begin
      s1          <= btn;
      s2          <= s1;
      stable      <= stable_nxt;
      press_pulse <= stable_nxt & ~stable;
      toggle      <= toggle_nxt;
      led         <= led_nxt;
      blk_cnt     <= blk_cnt_nxt;
      wave        <= wave_nxt;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
`ifdef PRESS_COUNT_EN
      for (int i = 0; i < N_CH; i++) begin
        press_count[8*i +: 8] <= press_count[8*i +: 8] + 8'(press_pulse[i]);
      end
`endif
    end
  end

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Testbench for btn_led_ctrl (N_CH=4, DEB_CYCLES=4, BLINK_HALF=3).
// A behavioural reference model pushes the expected {led, press_pulse} after
// every clock edge into a queue; a negedge monitor pops and compares.
// Directed checks cover reset, glitch rejection, toggle, invert/blink and
// asynchronous reset mid-operation.

module tb_btn_led_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned BH = 3;

  logic           clk;
  logic           rst;
  logic [N-1:0]   btn;
  logic [2*N-1:0] mode;
  logic [N-1:0]   led;
  logic [N-1:0]   press_pulse;
`ifdef PRESS_COUNT_EN
  logic [8*N-1:0] press_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  btn_led_ctrl #(
    .N_CH      (N),
    .DEB_CYCLES(DB),
    .BLINK_HALF(BH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn),
    .mode       (mode),
    .led        (led),
    .press_pulse(press_pulse)
`ifdef PRESS_COUNT_EN
    ,
    .press_count(press_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model
  logic [N-1:0] m_s1, m_s2, m_stable, m_pp, m_tog, m_led;
  int           m_cnt [N];
  int           m_bcnt;
  logic         m_wave;
  logic [2*N-1:0] exp_q [$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_pp = '0; m_tog = '0; m_led = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_bcnt = 0;
      m_wave = 1'b0;
      exp_q.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        logic old_st;
        logic [1:0] md;
        old_st = m_stable[i];
        if (m_s2[i] == m_stable[i]) m_cnt[i] = 0;
        else if (m_cnt[i] == DB - 1) begin
          m_stable[i] = m_s2[i];
          m_cnt[i] = 0;
        end else m_cnt[i] = m_cnt[i] + 1;
        md = mode[2*i +: 2];
        if (m_pp[i] && md == 2'b10) m_tog[i] = ~m_tog[i];
        case (md)
          2'b00: m_led[i] = old_st;
          2'b01: m_led[i] = ~old_st;
          2'b10: m_led[i] = m_tog[i];
          default: m_led[i] = old_st & m_wave;
        endcase
        m_pp[i] = m_stable[i] & ~old_st;
      end
      m_s2 = m_s1;
      m_s1 = btn;
      if (m_bcnt == BH - 1) begin
        m_bcnt = 0;
        m_wave = ~m_wave;
      end else m_bcnt = m_bcnt + 1;
      exp_q.push_back({m_led, m_pp});
    end
  end

  // Monitor: outputs are zero in reset, otherwise match the scoreboard
  int obs_pulses [N];
  initial for (int i = 0; i < N; i++) obs_pulses[i] = 0;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_led", 32'(led), 32'h0);
      check("rst_pulse", 32'(press_pulse), 32'h0);
    end else if (exp_q.size() > 0) begin
      logic [2*N-1:0] e;
      e = exp_q.pop_front();
      check("sb_led", 32'(led), 32'(e[2*N-1:N]));
      check("sb_pulse", 32'(press_pulse), 32'(e[N-1:0]));
      for (int i = 0; i < N; i++) obs_pulses[i] += int'(press_pulse[i]);
    end else begin
      check("sb_empty", 32'h0, 32'h1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  int base [N];
  task automatic snap();
    for (int i = 0; i < N; i++) base[i] = obs_pulses[i];
  endtask

  initial begin
    rst  = 1'b0;
    btn  = 4'hF;
    mode = '0;
    #1 rst = 1'b1;

    // 1: buttons held through reset release
    tick(3);
    snap();
    rst = 1'b0;
    tick(10);
    check("t1_led", 32'(led), 32'hF);
    for (int i = 0; i < N; i++) check("t1_pulses", 32'(obs_pulses[i] - base[i]), 32'd1);
    btn = '0;
    tick(10);
    check("t1_release", 32'(led), 32'h0);

    // 2: 3-cycle glitch rejected, 10-cycle hold accepted
    snap();
    btn = 4'b0001;
    tick(3);
    btn = '0;
    tick(10);
    check("t2_glitch_led", 32'(led[0]), 32'h0);
    check("t2_glitch_pulse", 32'(obs_pulses[0] - base[0]), 32'd0);
    btn = 4'b0001;
    tick(10);
    check("t2_hold_led", 32'(led[0]), 32'h1);
    check("t2_hold_pulse", 32'(obs_pulses[0] - base[0]), 32'd1);
    btn = '0;
    tick(10);

    // 3: toggle mode on ch1
    mode = 8'b00_00_10_00;
    tick(2);
    snap();
    btn = 4'b0010; tick(8); btn = '0; tick(8);
    check("t3_first", 32'(led[1]), 32'h1);
    btn = 4'b0010; tick(8); btn = '0; tick(8);
    check("t3_second", 32'(led[1]), 32'h0);
    check("t3_pulses", 32'(obs_pulses[1] - base[1]), 32'd2);
    btn = 4'b0010; tick(8); btn = '0; tick(8);
    check("t3_third", 32'(led[1]), 32'h1);
    mode = 8'b00_00_00_00;
    tick(2);
    check("t3_direct", 32'(led[1]), 32'h0);
    mode = 8'b00_00_10_00;
    tick(2);
    check("t3_kept", 32'(led[1]), 32'h1);

    // 4: invert on ch2, blink on ch3
    mode = 8'b11_01_10_00;
    tick(2);
    check("t4_invert", 32'(led[2]), 32'h1);
    btn = 4'b1000;
    tick(30);
    btn = '0;
    tick(10);
    check("t4_blink_off", 32'(led[3]), 32'h0);

    // 5: async reset mid-debounce with ch1 toggle state set
    btn = 4'b0001;
    tick(4);
    check("t5_pre_led", 32'(led), 32'h6);
    #2 rst = 1'b1;
    #1;
    check("t5_async_led", 32'(led), 32'h0);
    check("t5_async_pulse", 32'(press_pulse), 32'h0);
    tick(2);
    snap();
    rst = 1'b0;
    tick(5);
    check("t5_early", 32'(led[0]), 32'h0);
    tick(2);
    check("t5_led0", 32'(led[0]), 32'h1);
    check("t5_tog_cleared", 32'(led[1]), 32'h0);
    check("t5_invert", 32'(led[2]), 32'h1);
    check("t5_pulse", 32'(obs_pulses[0] - base[0]), 32'd1);
    btn = '0;
    tick(10);

    // Random traffic against the scoreboard
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) btn = btn ^ 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) mode = 8'($urandom);
      tick(1);
    end

`ifdef PRESS_COUNT_EN
    // 257 presses on ch0 wrap the counter to 1
    btn  = '0;
    mode = '0;
    #2 rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    for (int p = 0; p < 257; p++) begin
      btn = 4'b0001; tick(7);
      btn = '0;      tick(7);
    end
    tick(3);
    check("pc_ch0", 32'(press_count[7:0]), 32'h1);
    check("pc_others", 32'(press_count[31:8]), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
